// File: rtl/prog_loader_if.sv
// Byte-stream handshake and instruction-memory write bus for the program loader.
// The master modport is the loader side; the slave modport is the host/memory side.
interface prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses a length-prefixed big-endian byte stream into 16-bit
// instruction words, writes them from address 0 and holds the CPU until done.
module prog_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    prog_loader_if.master     bus,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   words_loaded_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_FLUSH, S_DONE, S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              hold_q, hold_d;

    logic              xfer_s;
    logic [15:0]       len_new_s;
    logic              len_bad_s;
    logic [ADDR_W:0]   words_inc_s;
    logic              last_s;

    assign xfer_s      = bus.in_valid && in_ready_q;
    assign len_new_s   = {len_q[15:8], bus.in_data};
    assign len_bad_s   = (len_new_s == 16'h0000) || (len_new_s > 16'(DEPTH));
    assign words_inc_s = words_q + {{ADDR_W{1'b0}}, 1'b1};
    assign last_s      = (16'(words_inc_s) == len_q);

    // Next-state, datapath updates and registered-output decode of the next state.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        hi_d      = hi_q;
        words_d   = words_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d = S_LEN_HI;
                    words_d = {(ADDR_W+1){1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN_HI: begin
                if (xfer_s) begin
                    len_d   = {bus.in_data, 8'h00};
                    state_d = S_LEN_LO;
                end else begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_LO: begin
                if (xfer_s) begin
                    len_d   = len_new_s;
                    state_d = len_bad_s ? S_ERR : S_DATA_HI;
                end else begin
                    state_d = S_LEN_LO;
                end
            end
            S_DATA_HI: begin
                if (xfer_s) begin
                    hi_d    = bus.in_data;
                    state_d = S_DATA_LO;
                end else begin
                    state_d = S_DATA_HI;
                end
            end
            S_DATA_LO: begin
                if (xfer_s) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = words_q[ADDR_W-1:0];
                    wr_data_d = {hi_q, bus.in_data};
                    words_d   = words_inc_s;
                    state_d   = last_s ? S_FLUSH : S_DATA_HI;
                end else begin
                    state_d = S_DATA_LO;
                end
            end
            // Gives the final write a cycle to land before the CPU is released.
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_DATA_HI) || (state_d == S_DATA_LO);
        busy_d     = in_ready_d || (state_d == S_FLUSH);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
        hold_d     = (state_d != S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= 16'h0000;
            hi_q       <= 8'h00;
            words_q    <= {(ADDR_W+1){1'b0}};
            wr_en_q    <= 1'b0;
            wr_addr_q  <= {ADDR_W{1'b0}};
            wr_data_q  <= 16'h0000;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            hold_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            hi_q       <= hi_d;
            words_q    <= words_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            hold_q     <= hold_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign cpu_hold_o     = hold_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and randomized loads checked
// against a stream-parsing reference model of the expected memory writes.
module tb_prog_loader;

    typedef logic [7:0] byte_q_t [$];

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       error;
    logic [8:0] words_loaded;

    int checks;
    int failures;
    int cyc;
    int last_wr_cyc;
    int done_cyc;
    logic done_prev;
    logic [23:0] wr_q  [$];
    logic [23:0] exp_q [$];

    prog_loader_if #(.ADDR_W(8)) bus ();

    prog_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .bus            (bus),
        .cpu_hold_o     (cpu_hold),
        .busy_o         (busy),
        .done_o         (done),
        .error_o        (error),
        .words_loaded_o (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-bus and done-rise monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wr_q.push_back({bus.wr_addr, bus.wr_data});
            last_wr_cyc = cyc;
        end
        if (done === 1'b1 && done_prev !== 1'b1 && done_cyc < 0) done_cyc = cyc;
        done_prev = done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(n < 64), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Reference: parse the stream into its expected (addr, data) writes.
    function automatic bit model(input byte_q_t b, output int len);
        bit err;
        len = (int'(b[0]) << 8) | int'(b[1]);
        err = (len == 0) || (len > 256);
        exp_q.delete();
        if (!err)
            for (int i = 0; i < len; i++)
                exp_q.push_back({8'(i), b[2 + 2*i], b[3 + 2*i]});
        return err;
    endfunction

    task automatic run_load(input byte_q_t b, input int gapmax, input int start_at, input string tag);
        bit err;
        int len;
        err = model(b, len);
        wr_q.delete();
        done_cyc = -1;
        do_start();
        for (int i = 0; i < b.size(); i++) begin
            if (i == start_at) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(b[i], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
        end
        if (err) begin
            check({tag, "_err_now"}, 32'(error), 32'd1);
            check({tag, "_rdy_now"}, 32'(bus.in_ready), 32'd0);
        end
        repeat (4) @(negedge clk);
        check({tag, "_nwr"}, 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check({tag, "_wr"}, 32'(wr_q[i]), 32'(exp_q[i]));
        check({tag, "_done"},  32'(done), 32'(!err));
        check({tag, "_error"}, 32'(error), 32'(err));
        check({tag, "_hold"},  32'(cpu_hold), 32'(err));
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_rdy"},   32'(bus.in_ready), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), err ? 32'd0 : 32'(len));
        if (!err) check({tag, "_done_lat"}, 32'(done_cyc), 32'(last_wr_cyc + 1));
    endtask

    initial begin
        byte_q_t s;
        int      len;
        checks = 0; failures = 0; cyc = 0;
        last_wr_cyc = 0; done_cyc = -1; done_prev = 1'b0;
        start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_hold",  32'(cpu_hold), 32'd1);
        check("rst_rdy",   32'(bus.in_ready), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_addr",  32'(bus.wr_addr), 32'd0);
        check("rst_data",  32'(bus.wr_data), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_rdy",  32'(bus.in_ready), 32'd0);
        check("post_rst_hold", 32'(cpu_hold), 32'd1);

        s = '{8'h00, 8'h03, 8'h2A, 8'h41, 8'h00, 8'h00, 8'hE0, 8'h05};
        run_load(s, 0, -1, "nominal");

        // Restart from DONE clears status on the next cycle.
        do_start();
        check("restart_hold",  32'(cpu_hold), 32'd1);
        check("restart_done",  32'(done), 32'd0);
        check("restart_words", 32'(words_loaded), 32'd0);
        check("restart_rdy",   32'(bus.in_ready), 32'd1);
        s = '{8'h00, 8'h01, 8'h55, 8'h66};
        for (int i = 0; i < s.size(); i++) send_byte(s[i], 0);
        repeat (3) @(negedge clk);
        check("restart_fin", 32'(done), 32'd1);

        s = '{8'h00, 8'h03, 8'h2A, 8'h41, 8'h00, 8'h00, 8'hE0, 8'h05};
        run_load(s, 3, -1, "gaps");

        s = '{8'h00, 8'h00};
        run_load(s, 0, -1, "len0");
        s = '{8'h01, 8'h01};
        run_load(s, 0, -1, "len257");
        len = int'($urandom_range(65535, 257));
        s = '{8'(len >> 8), 8'(len)};
        run_load(s, 2, -1, "lenbig");

        s = '{8'h00, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34};
        run_load(s, 0, 4, "start_busy");

        for (int r = 0; r < 4; r++) begin
            len = int'($urandom_range(8, 1));
            s = '{8'h00, 8'(len)};
            for (int i = 0; i < 2*len; i++) s.push_back(8'($urandom));
            run_load(s, 2, -1, "rand");
        end

        s = '{8'h01, 8'h00};
        for (int i = 0; i < 512; i++) s.push_back(8'($urandom));
        run_load(s, 0, -1, "len256");

        // Asynchronous reset in the middle of a load.
        do_start();
        s = '{8'h00, 8'h03, 8'h11, 8'h22};
        for (int i = 0; i < s.size(); i++) send_byte(s[i], 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_hold",  32'(cpu_hold), 32'd1);
        check("mid_rst_busy",  32'(busy), 32'd0);
        check("mid_rst_rdy",   32'(bus.in_ready), 32'd0);
        check("mid_rst_words", 32'(words_loaded), 32'd0);
        check("mid_rst_addr",  32'(bus.wr_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        s = '{8'h00, 8'h01, 8'h12, 8'h34};
        run_load(s, 0, -1, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
